// File: rtl/taillight_pkg.sv
// Shared types and defaults for the taillight input conditioner.
// Optional feature macro: TAILLIGHT_BRAKE_STRETCH_EN (minimum brake-on time).
package taillight_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 4;
    localparam int unsigned DEF_GAP_CYCLES        = 5;
    localparam int unsigned DEF_BRAKE_HOLD_CYCLES = 20;

    // Width of a counter that must hold values 0..max without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max);
        int unsigned w;
        w = $clog2(max + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/taillight_input_conditioner_debounce_channel.sv
// One raw input channel: 2-flop synchroniser followed by a level debouncer.
// A level change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_channel
    import taillight_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    // Synchronise the raw contact, then count consecutive samples that differ from the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt >= LAST) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_db;

endmodule

// File: rtl/taillight_input_conditioner.sv
// Taillight input conditioner: debounces stalk/brake inputs, arbitrates turn
// direction with a blank gap on reversal, and flags simultaneous turn requests.
// Optional feature macro: TAILLIGHT_BRAKE_STRETCH_EN (brake held >= BRAKE_HOLD_CYCLES).
module taillight_input_conditioner
    import taillight_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned GAP_CYCLES        = DEF_GAP_CYCLES,
    parameter int unsigned BRAKE_HOLD_CYCLES = DEF_BRAKE_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_turn_left,
    input  logic raw_turn_right,
    input  logic raw_brake,
    output logic turn_left,
    output logic turn_right,
    output logic brake,
    output logic conflict
);

    localparam int unsigned GCW = cnt_width(GAP_CYCLES);
    localparam logic [GCW-1:0] GAP_DONE = GCW'(GAP_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
        BRAKE_HOLD_CYCLES < 1 || BRAKE_HOLD_CYCLES > 255) begin : g_param_range
        $error("taillight_input_conditioner: parameter out of range 1..255");
    end

    logic w_dl;
    logic w_dr;
    logic w_db_brake;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .rst(rst), .i_raw(raw_turn_left), .o_level(w_dl)
    );
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .rst(rst), .i_raw(raw_turn_right), .o_level(w_dr)
    );
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_brake (
        .clk(clk), .rst(rst), .i_raw(raw_brake), .o_level(w_db_brake)
    );

    arb_state_t     r_state;
    arb_state_t     w_next;
    logic [GCW-1:0] r_gap_cnt;
    logic           r_conf_armed;
    logic           w_idle_eval;
    logic           w_conflict;
    logic           r_turn_left;
    logic           r_turn_right;
    logic           r_conflict;
    logic           r_brake;

    // State register plus gap timer; the timer restarts on every entry into GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gap_cnt    <= '0;
            r_conf_armed <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_conf_armed <= w_idle_eval & w_dl & w_dr;
            if (r_state != GAP) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != GAP_DONE) begin
                r_gap_cnt <= r_gap_cnt + GCW'(1);
            end
        end
    end

    // Next state; an expired GAP takes the IDLE decision directly to save a cycle.
    always_comb begin
        w_idle_eval = (r_state == IDLE) || ((r_state == GAP) && (r_gap_cnt == GAP_DONE));
        w_next      = r_state;
        if (w_idle_eval) begin
            if (w_dl && !w_dr) begin
                w_next = LEFT;
            end else if (w_dr && !w_dl) begin
                w_next = RIGHT;
            end else begin
                w_next = IDLE;
            end
        end else begin
            case (r_state)
                LEFT:    w_next = w_dl ? LEFT  : (w_dr ? GAP : IDLE);
                RIGHT:   w_next = w_dr ? RIGHT : (w_dl ? GAP : IDLE);
                default: w_next = GAP;
            endcase
        end
    end

    // Conflict fires only on the first IDLE decision that sees both turns requested.
    always_comb begin
        w_conflict = w_idle_eval & w_dl & w_dr & ~r_conf_armed;
    end

    // Registered turn/conflict outputs, aligned with the state update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_turn_left  <= 1'b0;
            r_turn_right <= 1'b0;
            r_conflict   <= 1'b0;
        end else begin
            r_turn_left  <= (w_next == LEFT);
            r_turn_right <= (w_next == RIGHT);
            r_conflict   <= w_conflict;
        end
    end

`ifdef TAILLIGHT_BRAKE_STRETCH_EN
    localparam int unsigned HCW = cnt_width(BRAKE_HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(BRAKE_HOLD_CYCLES - 1);

    logic [HCW-1:0] r_hold_cnt;

    // Brake output with minimum on-time; a rise while already held does not reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brake    <= 1'b0;
            r_hold_cnt <= '0;
        end else if (!r_brake && w_db_brake) begin
            r_brake    <= 1'b1;
            r_hold_cnt <= HOLD_LOAD;
        end else if (r_hold_cnt != '0) begin
            r_brake    <= 1'b1;
            r_hold_cnt <= r_hold_cnt - HCW'(1);
        end else begin
            r_brake    <= w_db_brake;
        end
    end
`else
    // Brake output follows the debounced brake level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brake <= 1'b0;
        end else begin
            r_brake <= w_db_brake;
        end
    end
`endif

    assign turn_left  = r_turn_left;
    assign turn_right = r_turn_right;
    assign brake      = r_brake;
    assign conflict   = r_conflict;

endmodule
